// File: rtl/sfm_tcdm_arbiter.sv
// Round-robin arbiter sharing the wide TCDM master port between NR requesters.
// An in-order ID FIFO of outstanding reads steers each response back to its issuer.
module sfm_tcdm_arbiter #(
  parameter int unsigned NR      = 2,
  parameter int unsigned DW      = 128,
  parameter int unsigned AW      = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic [NR-1:0]                      req_i,
  output logic [NR-1:0]                      gnt_o,
  input  logic [NR-1:0][AW-1:0]              add_i,
  input  logic [NR-1:0]                      wen_i,
  input  logic [NR-1:0][DW/8-1:0]            be_i,
  input  logic [NR-1:0][DW-1:0]              data_i,
  output logic [NR-1:0]                      r_valid_o,
  input  logic [NR-1:0]                      r_ready_i,
  output logic [DW-1:0]                      r_data_o,
  output logic                               tcdm_req_o,
  input  logic                               tcdm_gnt_i,
  output logic [AW-1:0]                      tcdm_add_o,
  output logic                               tcdm_wen_o,
  output logic [DW/8-1:0]                    tcdm_be_o,
  output logic [DW-1:0]                      tcdm_data_o,
  input  logic                               tcdm_r_valid_i,
  input  logic [DW-1:0]                      tcdm_r_data_i,
  output logic                               tcdm_r_ready_o,
  output logic [$clog2(MAX_OUT+1)-1:0]       outstanding_o,
  output logic                               err_o
);

  localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;
  localparam int unsigned PW = $clog2(MAX_OUT);
  localparam int unsigned CW = $clog2(MAX_OUT+1);

  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel_q;
  logic [IW-1:0] sel_rr;
  logic [IW-1:0] sel;
  logic [IW-1:0] next_rr;
  logic [NR-1:0] eligible;
  logic          found;

  logic [IW-1:0] id_mem [MAX_OUT];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] head;
  logic          hs;
  logic          push;
  logic          pop;
  logic          err_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head       = id_mem[rd_ptr[PW-1:0]];

  // Reads stall on the registered full flag; writes never touch the FIFO.
  always_comb begin
    int unsigned idx;
    eligible = req_i & ~(wen_i & {NR{fifo_full}});
    sel_rr   = rr_ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(rr_ptr) + k) % NR;
      if (!found && eligible[IW'(idx)]) begin
        sel_rr = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign sel        = (state == ARB_LOCKED) ? sel_q : sel_rr;
  assign next_rr    = (sel == IW'(NR-1)) ? '0 : sel + IW'(1);
  assign tcdm_req_o = ~clear_i & ((state == ARB_LOCKED) | (|eligible));
  assign tcdm_add_o  = add_i[sel];
  assign tcdm_wen_o  = wen_i[sel];
  assign tcdm_be_o   = be_i[sel];
  assign tcdm_data_o = data_i[sel];

  assign hs   = tcdm_req_o & tcdm_gnt_i;
  assign push = hs & tcdm_wen_o;

  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = hs;
  end

  always_comb begin
    r_valid_o = '0;
    if (!fifo_empty) r_valid_o[head] = tcdm_r_valid_i;
  end

  // With nothing outstanding, stray responses are drained rather than stalling the bus.
  assign tcdm_r_ready_o = fifo_empty ? 1'b1 : r_ready_i[head];
  assign pop            = tcdm_r_valid_i & tcdm_r_ready_o & ~fifo_empty;
  assign r_data_o       = tcdm_r_data_i;

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr[PW-1:0]] <= sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ARB_FREE;
      sel_q  <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else if (clear_i) begin
      state  <= ARB_FREE;
      sel_q  <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ARB_FREE: begin
          if (tcdm_req_o && !tcdm_gnt_i) begin
            state <= ARB_LOCKED;
            sel_q <= sel;
          end
        end
        ARB_LOCKED: begin
          if (tcdm_gnt_i) state <= ARB_FREE;
        end
        default: state <= ARB_FREE;
      endcase
      if (hs)   rr_ptr <= next_rr;
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (tcdm_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = count;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sfm_tcdm_arbiter.sv
// Self-checking bench for sfm_tcdm_arbiter: arbitration, locking, response
// steering via a response scoreboard, full-FIFO stall, backpressure, error and reset.
module tb_sfm_tcdm_arbiter;

  localparam int unsigned NR      = 2;
  localparam int unsigned DW      = 128;
  localparam int unsigned AW      = 32;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CW      = $clog2(MAX_OUT+1);

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     clear_i;
  logic [NR-1:0]            req_i;
  logic [NR-1:0]            gnt_o;
  logic [NR-1:0][AW-1:0]    add_i;
  logic [NR-1:0]            wen_i;
  logic [NR-1:0][DW/8-1:0]  be_i;
  logic [NR-1:0][DW-1:0]    data_i;
  logic [NR-1:0]            r_valid_o;
  logic [NR-1:0]            r_ready_i;
  logic [DW-1:0]            r_data_o;
  logic                     tcdm_req_o;
  logic                     tcdm_gnt_i;
  logic [AW-1:0]            tcdm_add_o;
  logic                     tcdm_wen_o;
  logic [DW/8-1:0]          tcdm_be_o;
  logic [DW-1:0]            tcdm_data_o;
  logic                     tcdm_r_valid_i;
  logic [DW-1:0]            tcdm_r_data_i;
  logic                     tcdm_r_ready_o;
  logic [CW-1:0]            outstanding_o;
  logic                     err_o;

  typedef struct {
    int unsigned    id;
    logic [DW-1:0]  data;
  } rsp_t;

  rsp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sfm_tcdm_arbiter #(
    .NR(NR), .DW(DW), .AW(AW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .data_i(data_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .tcdm_r_ready_o(tcdm_r_ready_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  function automatic logic [DW-1:0] rsp_data(input logic [AW-1:0] a);
    return {4{32'hD000_0000 ^ a}};
  endfunction

  // Drive the scoreboard head as the bus response and check routing to its issuer.
  task automatic respond(input logic [NR-1:0] ready);
    rsp_t          e;
    logic [NR-1:0] ev;
    e              = sb[0];
    ev             = '0;
    ev[e.id]       = 1'b1;
    tcdm_r_valid_i = 1'b1;
    tcdm_r_data_i  = e.data;
    r_ready_i      = ready;
    settle();
    check_eq("rsp_valid", r_valid_o, ev);
    check_eq("rsp_data", r_data_o, e.data);
    check_eq("rsp_ready", tcdm_r_ready_o, ready[e.id]);
    if (ready[e.id]) void'(sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; req_i = '0; add_i = '0; wen_i = '0;
    be_i = '0; data_i = '0; r_ready_i = '1; tcdm_gnt_i = 1'b0;
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = 128'h1234_5678;

    // Reset state
    settle();
    check_eq("rst_outstanding", outstanding_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_req", tcdm_req_o, 0);
    check_eq("rst_gnt", gnt_o, 0);
    check_eq("rst_rvalid", r_valid_o, 0);
    check_eq("rst_rdata", r_data_o, 128'h1234_5678);
    tick();
    rst_ni = 1'b1;

    // Round-robin with continuous writes
    tick();
    req_i = 2'b11; wen_i = 2'b00; tcdm_gnt_i = 1'b1;
    add_i[0] = 32'hA0; add_i[1] = 32'hB0;
    data_i[0] = 128'hAAAA; data_i[1] = 128'hBBBB;
    be_i[0] = 16'h0F0F; be_i[1] = 16'hF0F0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      settle();
      check_eq("rr_gnt", gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("rr_add", tcdm_add_o, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      check_eq("rr_data", tcdm_data_o, (k % 2 == 0) ? 128'hAAAA : 128'hBBBB);
      check_eq("rr_be", tcdm_be_o, (k % 2 == 0) ? 16'h0F0F : 16'hF0F0);
    end

    // Lock: move rr pointer to 1, then stall requester 0 while requester 1 rises
    tick();
    req_i = 2'b01; add_i[0] = 32'h111; add_i[1] = 32'h222;
    settle();
    check_eq("pre_lock_gnt", gnt_o, 2'b01);
    tick();
    tcdm_gnt_i = 1'b0;
    settle();
    check_eq("lock_c1_add", tcdm_add_o, 32'h111);
    check_eq("lock_c1_req", tcdm_req_o, 1);
    check_eq("lock_c1_gnt", gnt_o, 2'b00);
    tick();
    req_i = 2'b11;
    settle();
    check_eq("lock_c2_add", tcdm_add_o, 32'h111);
    tick();
    settle();
    check_eq("lock_c3_add", tcdm_add_o, 32'h111);
    tick();
    tcdm_gnt_i = 1'b1;
    settle();
    check_eq("lock_gnt", gnt_o, 2'b01);
    check_eq("lock_gnt_add", tcdm_add_o, 32'h111);
    tick();
    settle();
    check_eq("after_lock_gnt", gnt_o, 2'b10);
    check_eq("after_lock_add", tcdm_add_o, 32'h222);

    // Response steering (rr pointer now 0)
    tick();
    req_i = 2'b01; wen_i = 2'b01; add_i[0] = 32'h100;
    sb.push_back('{id: 0, data: rsp_data(32'h100)});
    settle();
    check_eq("rd0_gnt", gnt_o, 2'b01);
    tick();
    req_i = 2'b10; wen_i = 2'b10; add_i[1] = 32'h200;
    sb.push_back('{id: 1, data: rsp_data(32'h200)});
    settle();
    check_eq("rd1_gnt", gnt_o, 2'b10);
    check_eq("steer_out1", outstanding_o, 1);
    tick();
    req_i = 2'b00;
    respond(2'b11);
    check_eq("steer_out2", outstanding_o, 2);
    tick();
    respond(2'b11);
    check_eq("steer_out3", outstanding_o, 1);
    tick();
    tcdm_r_valid_i = 1'b0;
    settle();
    check_eq("steer_out4", outstanding_o, 0);

    // Fill the FIFO: ids 0,0,0,1 (rr pointer ends at 0)
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      a = 32'h300 + 32'(k);
      tick();
      if (k < 3) begin
        req_i = 2'b01; wen_i = 2'b01; add_i[0] = a;
      end else begin
        req_i = 2'b10; wen_i = 2'b10; add_i[1] = a;
      end
      sb.push_back('{id: (k < 3) ? 0 : 1, data: rsp_data(a)});
      settle();
      check_eq("fill_gnt", gnt_o, (k < 3) ? 2'b01 : 2'b10);
    end
    tick();
    req_i = 2'b11; wen_i = 2'b01; add_i[0] = 32'h400; add_i[1] = 32'h500;
    settle();
    check_eq("full_out", outstanding_o, 4);
    check_eq("full_wr_gnt", gnt_o, 2'b10);
    check_eq("full_wr_add", tcdm_add_o, 32'h500);
    check_eq("full_wr_wen", tcdm_wen_o, 0);
    tick();
    req_i = 2'b01;
    settle();
    check_eq("full_rd_req", tcdm_req_o, 0);
    check_eq("full_rd_stall", gnt_o, 2'b00);
    tick();
    respond(2'b11);
    check_eq("full_pop_gnt", gnt_o, 2'b00);
    tick();
    tcdm_r_valid_i = 1'b0;
    sb.push_back('{id: 0, data: rsp_data(32'h400)});
    settle();
    check_eq("full_late_gnt", gnt_o, 2'b01);
    check_eq("full_late_add", tcdm_add_o, 32'h400);
    check_eq("full_late_wen", tcdm_wen_o, 1);
    check_eq("full_late_out", outstanding_o, 3);
    tick();
    req_i = 2'b00;
    settle();
    check_eq("refill_out", outstanding_o, 4);

    // Backpressure on the head requester
    for (int k = 0; k < 2; k++) begin
      tick();
      respond(2'b00);
      check_eq("bp_out", outstanding_o, 4);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      respond(2'b11);
    end
    tick();
    tcdm_r_valid_i = 1'b0;
    settle();
    check_eq("drain_out", outstanding_o, 0);

    // Stray response with empty FIFO
    tick();
    tcdm_r_valid_i = 1'b1;
    settle();
    check_eq("stray_rvalid", r_valid_o, 2'b00);
    check_eq("stray_ready", tcdm_r_ready_o, 1);
    tick();
    tcdm_r_valid_i = 1'b0;
    settle();
    check_eq("err_set", err_o, 1);
    tick();
    tick();
    settle();
    check_eq("err_sticky", err_o, 1);

    // Asynchronous reset with two reads outstanding
    tick();
    req_i = 2'b01; wen_i = 2'b11; add_i[0] = 32'h600;
    tick();
    req_i = 2'b10; add_i[1] = 32'h700;
    tick();
    req_i = 2'b00;
    settle();
    check_eq("pre_rst_out", outstanding_o, 2);
    rst_ni = 1'b0;
    tcdm_r_data_i = 128'hABCD;
    #1;
    check_eq("async_rst_out", outstanding_o, 0);
    check_eq("async_rst_err", err_o, 0);
    check_eq("async_rst_rdata", r_data_o, 128'hABCD);
    sb.delete();
    tick();
    rst_ni = 1'b1;

    // Synchronous clear of a sticky error
    tick();
    tcdm_r_valid_i = 1'b1;
    tick();
    tcdm_r_valid_i = 1'b0;
    settle();
    check_eq("err_again", err_o, 1);
    tick();
    clear_i = 1'b1;
    settle();
    check_eq("clear_pending_err", err_o, 1);
    tick();
    clear_i = 1'b0;
    settle();
    check_eq("clear_err", err_o, 0);
    check_eq("clear_out", outstanding_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
